// File: rtl/sad_pkg.sv
// Shared types and constants for the SAD sequencer and anything that talks to it.
// The strobe decode lives here so the controller registers outputs from a single table.
package sad_pkg;

    localparam int SAD_N_SAMPLES = 256;
    localparam int SAD_ADDR_W    = 8;

    typedef enum logic [2:0] {
        SAD_IDLE,
        SAD_INIT,
        SAD_CHECK,
        SAD_READ,
        SAD_WAIT,
        SAD_ACC,
        SAD_LATCH,
        SAD_DONE
    } sad_state_t;

    typedef struct packed {
        logic i_inc;
        logic i_clr;
        logic sum_ld;
        logic sum_clr;
        logic sad_reg_ld;
        logic mem_rd;
        logic done;
    } sad_strobe_t;

    function automatic sad_strobe_t sad_decode(input sad_state_t s);
        sad_strobe_t st;
        st = '0;
        case (s)
            SAD_INIT: begin
                st.i_clr   = 1'b1;
                st.sum_clr = 1'b1;
            end
            SAD_READ:  st.mem_rd     = 1'b1;
            SAD_ACC: begin
                st.sum_ld = 1'b1;
                st.i_inc  = 1'b1;
            end
            SAD_LATCH: st.sad_reg_ld = 1'b1;
            SAD_DONE:  st.done       = 1'b1;
            default:   st = '0;
        endcase
        return st;
    endfunction

endpackage

// File: rtl/sad_ctrl.sv
// Sequencer for the sad_proc datapath: clears it, walks every sample pair through the
// memories with a programmable read latency, then latches the final sum.
//
//   state | meaning
//   IDLE  | waiting for go_i, all outputs low
//   INIT  | clear datapath index and sum, reset address
//   CHECK | decide between another element and finishing
//   READ  | read strobe to both memories, arm the latency counter
//   WAIT  | count down remaining memory latency
//   ACC   | accumulate |a-b|, advance index and address
//   LATCH | load datapath result register
//   DONE  | one-cycle completion pulse
module sad_ctrl
    import sad_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                  clk,
    input  logic                  rstn_i,
    input  logic                  go_i,
    input  logic                  abort_i,
    input  logic                  i_it_256,
    output logic                  i_inc,
    output logic                  i_clr,
    output logic                  sum_ld,
    output logic                  sum_clr,
    output logic                  sad_reg_ld,
    output logic                  mem_rd_o,
    output logic [SAD_ADDR_W-1:0] addr_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int               CNT_W     = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'((MEM_LAT > 1) ? MEM_LAT - 2 : 0);

    sad_state_t       state;
    sad_state_t       nxt;
    sad_strobe_t      stb_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             busy_q;
    logic             abort_act;

    assign abort_act = abort_i && (state != SAD_IDLE);

    always_comb begin
        nxt = state;
        case (state)
            SAD_IDLE:  if (go_i && !abort_i) nxt = SAD_INIT;
            SAD_INIT:  nxt = SAD_CHECK;
            SAD_CHECK: nxt = i_it_256 ? SAD_READ : SAD_LATCH;
            SAD_READ:  nxt = (MEM_LAT == 1) ? SAD_ACC : SAD_WAIT;
            SAD_WAIT:  if (wait_cnt == '0) nxt = SAD_ACC;
            SAD_ACC:   nxt = SAD_CHECK;
            SAD_LATCH: nxt = SAD_DONE;
            SAD_DONE:  nxt = SAD_IDLE;
            default:   nxt = SAD_IDLE;
        endcase
        if (abort_act) nxt = SAD_IDLE;
    end

    // Strobes are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge clk or negedge rstn_i) begin
        if (!rstn_i) begin
            state    <= SAD_IDLE;
            stb_q    <= '0;
            busy_q   <= 1'b0;
            wait_cnt <= '0;
            addr_o   <= '0;
        end else begin
            state  <= nxt;
            stb_q  <= sad_decode(nxt);
            busy_q <= (nxt != SAD_IDLE);
            if (state == SAD_READ) begin
                wait_cnt <= WAIT_LOAD;
            end else if (state == SAD_WAIT && wait_cnt != '0) begin
                wait_cnt <= wait_cnt - 1'b1;
            end
            if (state == SAD_INIT) begin
                addr_o <= '0;
            end else if (state == SAD_ACC && !abort_act) begin
                addr_o <= addr_o + 1'b1;
            end
        end
    end

    // An abort clears the datapath in the same cycle and suppresses every other strobe.
    assign i_clr      = stb_q.i_clr   | abort_act;
    assign sum_clr    = stb_q.sum_clr | abort_act;
    assign i_inc      = stb_q.i_inc      & ~abort_act;
    assign sum_ld     = stb_q.sum_ld     & ~abort_act;
    assign sad_reg_ld = stb_q.sad_reg_ld & ~abort_act;
    assign mem_rd_o   = stb_q.mem_rd     & ~abort_act;
    assign done_o     = stb_q.done       & ~abort_act;
    assign busy_o     = busy_q;

endmodule

// File: tb/tb_sad_ctrl.sv
// Bench for sad_ctrl: three controllers (latency 1, 3, 2), each with its own memory and
// datapath model; completion results are checked against a queue of expected runs.
module tb_sad_ctrl;
    import sad_pkg::*;

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : ((g == 1) ? 3 : 2);
    endfunction

    function automatic logic [7:0] mem_a(input int m, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        case (m)
            0:       return 8'h5A;
            1:       return 8'hFF;
            default: return kk;
        endcase
    endfunction

    function automatic logic [7:0] mem_b(input int m, input int k);
        logic [7:0] kk;
        kk = 8'(k);
        case (m)
            0:       return 8'h5A;
            1:       return 8'h00;
            default: return 8'd255 - kk;
        endcase
    endfunction

    function automatic logic [16:0] absd(input logic [15:0] p);
        logic [7:0] a;
        logic [7:0] b;
        a = p[15:8];
        b = p[7:0];
        return (a > b) ? 17'(a - b) : 17'(b - a);
    endfunction

    typedef struct {
        int inst;
        int dt;
        int cyc;
    } exp_t;

    logic clk;
    logic rstn;
    int   mode;
    int   cyc;
    int   errs;
    int   checks;
    int   done_cnt;
    int   rd_cnt   [3];
    int   exp_addr [3];
    int   last_rd  [3];
    int   busy_cnt [3];
    exp_t exp_q[$];

    logic        go_v     [3];
    logic        abort_v  [3];
    logic        it_v     [3];
    logic        i_inc_v  [3];
    logic        i_clr_v  [3];
    logic        sum_ld_v [3];
    logic        sum_clr_v[3];
    logic        ld_v     [3];
    logic        rd_v     [3];
    logic        busy_v   [3];
    logic        done_v   [3];
    logic [7:0]  addr_v   [3];
    logic [16:0] dt_v     [3];

    task automatic check_val(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int outs(input int g);
        return int'({busy_v[g], i_inc_v[g], i_clr_v[g], sum_ld_v[g], sum_clr_v[g],
                     ld_v[g], rd_v[g], done_v[g], addr_v[g]});
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_ch
        localparam int L = lat_of(g);
        logic [15:0] pipe [L];
        logic [8:0]  idx;
        logic [16:0] sum;
        logic [16:0] dt;

        sad_ctrl #(.MEM_LAT(L)) u_dut (
            .clk        (clk),
            .rstn_i     (rstn),
            .go_i       (go_v[g]),
            .abort_i    (abort_v[g]),
            .i_it_256   (it_v[g]),
            .i_inc      (i_inc_v[g]),
            .i_clr      (i_clr_v[g]),
            .sum_ld     (sum_ld_v[g]),
            .sum_clr    (sum_clr_v[g]),
            .sad_reg_ld (ld_v[g]),
            .mem_rd_o   (rd_v[g]),
            .addr_o     (addr_v[g]),
            .busy_o     (busy_v[g]),
            .done_o     (done_v[g])
        );

        assign it_v[g] = (idx < 9'(SAD_N_SAMPLES));
        assign dt_v[g] = dt;

        // Memory read pipeline plus a behavioural sad_proc datapath.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                for (int k = 0; k < L; k++) pipe[k] <= '0;
                idx <= '0;
                sum <= '0;
                dt  <= '0;
            end else begin
                pipe[0] <= rd_v[g] ? {mem_a(mode, int'(addr_v[g])), mem_b(mode, int'(addr_v[g]))} : 16'h0;
                for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
                if (i_clr_v[g]) idx <= '0;
                else if (i_inc_v[g]) idx <= idx + 9'd1;
                if (sum_clr_v[g]) sum <= '0;
                else if (sum_ld_v[g]) sum <= sum + absd(pipe[L-1]);
                if (ld_v[g]) dt <= sum;
            end
        end
    end

    always @(negedge clk) begin
        if (rstn) begin
            for (int g = 0; g < 3; g++) begin
                if (busy_v[g]) busy_cnt[g]++;
                if (rd_v[g]) begin
                    check_val("rd_addr", int'(addr_v[g]), exp_addr[g] % 256);
                    exp_addr[g]++;
                    rd_cnt[g]++;
                    last_rd[g] = cyc;
                end
                if (sum_ld_v[g]) check_val("rd_to_acc", cyc - last_rd[g], lat_of(g));
                if (done_v[g]) begin
                    if (exp_q.size() == 0) begin
                        check_val("unexpected_done", 1, 0);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check_val("done_inst", g, e.inst);
                        check_val("dt_o", int'(dt_v[g]), e.dt);
                        check_val("done_cycle", cyc, e.cyc);
                        check_val("rd_count", rd_cnt[g], SAD_N_SAMPLES);
                        check_val("addr_wrap", int'(addr_v[g]), 0);
                        check_val("busy_cycles", busy_cnt[g], SAD_N_SAMPLES * (lat_of(g) + 2) + 4);
                    end
                    done_cnt++;
                    rd_cnt[g]   = 0;
                    exp_addr[g] = 0;
                    busy_cnt[g] = 0;
                end
            end
        end
    end

    task automatic clear_track(input int g);
        rd_cnt[g]   = 0;
        exp_addr[g] = 0;
        busy_cnt[g] = 0;
    endtask

    task automatic start(input int g, input int m, input int exp_dt);
        exp_t e;
        @(negedge clk);
        mode = m;
        clear_track(g);
        e.inst = g;
        e.dt   = exp_dt;
        e.cyc  = cyc + SAD_N_SAMPLES * (lat_of(g) + 2) + 4;
        exp_q.push_back(e);
        go_v[g] = 1'b1;
        @(negedge clk);
        go_v[g] = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check_val("done_seen", done_cnt, target);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    initial begin
        int c0;
        int n;
        int seen;
        cyc      = 0;
        errs     = 0;
        checks   = 0;
        done_cnt = 0;
        mode     = 0;
        for (int g = 0; g < 3; g++) begin
            go_v[g]    = 1'b0;
            abort_v[g] = 1'b0;
            last_rd[g] = 0;
            clear_track(g);
        end
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) check_val("reset_outputs", outs(g), 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);

        // Identical memories, then max-difference data, then ramp data at latency 3.
        start(0, 0, 0);
        wait_done(1, 2000);
        start(0, 1, 65280);
        wait_done(2, 2000);
        start(1, 2, 32768);
        wait_done(3, 3000);

        // Abort a second run partway through.
        @(negedge clk);
        mode = 1;
        clear_track(0);
        c0 = cyc;
        go_v[0] = 1'b1;
        @(negedge clk);
        go_v[0] = 1'b0;
        while (cyc < c0 + 300) @(negedge clk);
        abort_v[0] = 1'b1;
        #1;
        check_val("abort_clears", int'({i_clr_v[0], sum_clr_v[0]}), 3);
        check_val("abort_strobes", int'({i_inc_v[0], sum_ld_v[0], ld_v[0], rd_v[0], done_v[0]}), 0);
        check_val("abort_busy", int'(busy_v[0]), 1);
        @(negedge clk);
        abort_v[0] = 1'b0;
        check_val("abort_idle", int'(busy_v[0]), 0);
        repeat (900) @(negedge clk);
        check_val("abort_no_done", done_cnt, 3);
        check_val("abort_dt_hold", int'(dt_v[0]), 65280);
        start(0, 2, 32768);
        wait_done(4, 2000);

        // go and abort together in IDLE.
        @(negedge clk);
        go_v[0]    = 1'b1;
        abort_v[0] = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_val("go_abort_idle", int'({busy_v[0], i_clr_v[0], sum_clr_v[0]}), 0);
        end
        go_v[0]    = 1'b0;
        abort_v[0] = 1'b0;

        // go held high: two back-to-back runs with one IDLE cycle between them.
        @(negedge clk);
        mode = 1;
        clear_track(0);
        c0 = cyc;
        exp_q.push_back('{0, 65280, c0 + 772});
        exp_q.push_back('{0, 65280, c0 + 773 + 772});
        go_v[0] = 1'b1;
        seen = 0;
        n = 0;
        while (seen < 2 && n < 4000) begin
            @(negedge clk);
            n++;
            if (done_v[0]) seen++;
        end
        go_v[0] = 1'b0;
        check_val("held_go_runs", seen, 2);
        repeat (5) @(negedge clk);
        check_val("held_go_stop", int'(busy_v[0]), 0);
        check_val("held_go_done_total", done_cnt, 6);

        // Asynchronous reset in the middle of a WAIT state at latency 2.
        start(2, 0, 0);
        n = 0;
        while (!rd_v[2] && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("saw_read", int'(rd_v[2]), 1);
        @(negedge clk);
        check_val("in_wait_busy", int'(busy_v[2]), 1);
        #2;
        rstn = 1'b0;
        #1;
        check_val("async_reset_outputs", outs(2), 0);
        exp_q.delete();
        @(negedge clk);
        rstn = 1'b1;
        clear_track(2);
        start(2, 1, 65280);
        wait_done(7, 2000);
        check_val("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
